// File: rtl/adder_result_stage.sv
// -----------------------------------------------------------------------------
// adder_result_stage
//
// Registered output stage that sits directly after the 32-bit carry-lookahead
// adder. It captures the sum, carry-out and overflow, derives the N/Z/C/V flags
// when a result is accepted, and presents them on a valid/ready handshake. A
// 2-entry skid buffer (main output register plus one overflow register) lets
// the adder issue every cycle while the consumer stalls, without losing data.
//
// Optional feature macro: STICKY_OVF_EN
//   When defined, ovf_sticky latches any accepted result with in_ovf=1 and is
//   cleared by clr_sticky (a set in the same cycle wins over the clear).
//   When undefined, ovf_sticky is tied to 0 and clr_sticky is ignored. The port
//   list is the same in both builds.
//
// Parameters
//   WIDTH       datapath width, must match the adder's sum width
//
// Ports
//   clk         in   1      single clock, rising edge
//   rst         in   1      synchronous reset, active-high
//   in_valid    in   1      adder result on in_sum/in_cout/in_ovf is valid
//   in_ready    out  1      stage can accept a result this cycle (registered)
//   in_sum      in   WIDTH  adder sum
//   in_cout     in   1      adder carry-out
//   in_ovf      in   1      adder signed overflow
//   out_valid   out  1      out_result/out_flags hold a valid entry
//   out_ready   in   1      consumer takes the entry this cycle
//   out_result  out  WIDTH  registered sum
//   out_flags   out  4      {N,Z,C,V} for out_result
//   clr_sticky  in   1      clear sticky overflow
//   ovf_sticky  out  1      sticky overflow
// -----------------------------------------------------------------------------
module adder_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_result_q, main_result_d;
    logic [3:0]       main_flags_q, main_flags_d;
    logic [WIDTH-1:0] skid_result_q, skid_result_d;
    logic [3:0]       skid_flags_q, skid_flags_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             drain;
    logic [3:0]       in_flags;

    always_comb begin
        accept   = in_valid & in_ready_q;
        drain    = out_valid_q & out_ready;
        in_flags = {in_sum[WIDTH-1], (in_sum == '0), in_cout, in_ovf};

        state_d       = state_q;
        main_result_d = main_result_q;
        main_flags_d  = main_flags_q;
        skid_result_d = skid_result_q;
        skid_flags_d  = skid_flags_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_result_d = in_sum;
                    main_flags_d  = in_flags;
                    state_d       = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_result_d = in_sum;
                    main_flags_d  = in_flags;
                end else if (accept) begin
                    // Consumer stalled: park the new result behind the output.
                    skid_result_d = in_sum;
                    skid_flags_d  = in_flags;
                    state_d       = ST_TWO;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can change state.
                if (drain) begin
                    main_result_d = skid_result_q;
                    main_flags_d  = skid_flags_q;
                    state_d       = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Handshake outputs are registered from the next state so that
        // in_ready has no combinational path from out_ready.
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            main_result_q <= '0;
            main_flags_q  <= 4'b0000;
            skid_result_q <= '0;
            skid_flags_q  <= 4'b0000;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            main_result_q <= main_result_d;
            main_flags_q  <= main_flags_d;
            skid_result_q <= skid_result_d;
            skid_flags_q  <= skid_flags_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = main_result_q;
    assign out_flags  = main_flags_q;

`ifdef STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // Set has priority over clear when both happen in the same cycle.
    always_comb begin
        sticky_d = (accept & in_ovf) | (sticky_q & ~clr_sticky);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign ovf_sticky        = 1'b0;
`endif

endmodule
